sseg_scan_mux: RTL and testbench

- Downstream display stage for the debounce/tick-counter test path.
- Takes a 16-bit value (four hex nibbles; the counter pair fills the low byte), per-digit decimal points and blank masks.
- Time-multiplexes the four digits onto the board's common-anode 7-segment display.
- Owns the refresh prescaler, hex decode, frame-synchronous input capture and active-low drive.

---
 rtl/sseg_scan_mux_if.sv | 30 +++
 rtl/sseg_scan_mux.sv | 156 +++++++++++++++
 tb/tb_sseg_scan_mux.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_mux_if.sv
// Display bundle between the value source and the 7-segment scan multiplexer.
// The master drives the value, decimal points and blank masks; the slave
// (the scan multiplexer) drives the active-low anode/segment lines and the
// frame boundary pulse.
interface sseg_scan_mux_if;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic [3:0]  an;
   logic [7:0]  sseg;
   logic        frame_tick;

   modport master (
      output value_in,
      output dp_in,
      output blank_in,
      input  an,
      input  sseg,
      input  frame_tick
   );

   modport slave (
      input  value_in,
      input  dp_in,
      input  blank_in,
      output an,
      output sseg,
      output frame_tick
   );
endinterface

// File: rtl/sseg_scan_mux.sv
// Four-digit common-anode 7-segment scan multiplexer.
// A free-running refresh counter selects one digit per quarter frame. The
// value, decimal points and blank masks are captured into shadow registers
// only at the frame boundary, so a frame never mixes old and new data.
// All outputs are registered and active-low; reset forces the display dark.
// Optional build macro: SSEG_LEADING_ZERO_BLANK_EN darkens leading zero digits
// (digits 3..1); when undefined every digit always shows its nibble.
module sseg_scan_mux #(
   parameter int REFRESH_BITS = 18
) (
   input  logic          clk,
   input  logic          n_reset,
   sseg_scan_mux_if.slave bus
);

   localparam logic [REFRESH_BITS-1:0] CNT_MAX = {REFRESH_BITS{1'b1}};
   localparam logic [REFRESH_BITS-1:0] CNT_ONE = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

   // Hex nibble to active-low segment pattern, bit order g..a.
   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         4'hF:    seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   // Active-low one-hot anode pattern for a digit index.
   function automatic logic [3:0] anode_sel(input logic [1:0] idx);
      logic [3:0] a;
      case (idx)
         2'd0:    a = 4'b1110;
         2'd1:    a = 4'b1101;
         2'd2:    a = 4'b1011;
         2'd3:    a = 4'b0111;
         default: a = 4'b1111;
      endcase
      return a;
   endfunction

   logic [REFRESH_BITS-1:0] cnt_q,     cnt_d;
   logic [15:0]             val_q,     val_d;
   logic [3:0]              dp_q,      dp_d;
   logic [3:0]              blank_q,   blank_d;
   logic [3:0]              an_q,      an_d;
   logic [7:0]              sseg_q,    sseg_d;
   logic                    tick_q,    tick_d;

   logic                    capture_s;
   logic [1:0]              idx_s;
   logic [3:0]              nib_s;
   logic                    lz_blank_s;
   logic                    dark_s;

   assign capture_s = (cnt_q == CNT_MAX);
   assign idx_s     = cnt_q[REFRESH_BITS-1 -: 2];

   // Select the shadow nibble belonging to the digit currently being scanned.
   always_comb begin
      nib_s = 4'h0;
      case (idx_s)
         2'd0:    nib_s = val_q[3:0];
         2'd1:    nib_s = val_q[7:4];
         2'd2:    nib_s = val_q[11:8];
         2'd3:    nib_s = val_q[15:12];
         default: nib_s = 4'h0;
      endcase
   end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more significant nibble is 0.
   always_comb begin
      lz_blank_s = 1'b0;
      case (idx_s)
         2'd3:    lz_blank_s = (val_q[15:12] == 4'h0);
         2'd2:    lz_blank_s = (val_q[15:8]  == 8'h00);
         2'd1:    lz_blank_s = (val_q[15:4]  == 12'h000);
         default: lz_blank_s = 1'b0;
      endcase
   end
`else
   assign lz_blank_s = 1'b0;
`endif

   assign dark_s = blank_q[idx_s] | lz_blank_s;

   // Next-state: counter advance and frame-boundary capture of the inputs.
   always_comb begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = capture_s;
      if (capture_s) begin
         val_d   = bus.value_in;
         dp_d    = bus.dp_in;
         blank_d = bus.blank_in;
      end else begin
         val_d   = val_q;
         dp_d    = dp_q;
         blank_d = blank_q;
      end
   end

   // Next-state: drive pattern for the digit selected by the current count.
   always_comb begin
      an_d   = 4'hF;
      sseg_d = 8'hFF;
      if (dark_s) begin
         an_d   = 4'hF;
         sseg_d = 8'hFF;
      end else begin
         an_d   = anode_sel(idx_s);
         sseg_d = {~dp_q[idx_s], hex_decode(nib_s)};
      end
   end

   // State and output registers; reset blanks the display and restarts the scan.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         cnt_q   <= {REFRESH_BITS{1'b0}};
         val_q   <= 16'h0000;
         dp_q    <= 4'h0;
         blank_q <= 4'h0;
         an_q    <= 4'hF;
         sseg_q  <= 8'hFF;
         tick_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         dp_q    <= dp_d;
         blank_q <= blank_d;
         an_q    <= an_d;
         sseg_q  <= sseg_d;
         tick_q  <= tick_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.sseg       = sseg_q;
   assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench for sseg_scan_mux with a 16-cycle frame (REFRESH_BITS=4).
// The driver issues stimulus on the falling edge and pushes the expected
// registered outputs for the following rising edge; the monitor pops and
// compares just after each rising edge.
module tb_sseg_scan_mux;
   localparam int RB    = 4;
   localparam int FRAME = 16;
   localparam int SLOT  = 4;

   logic clk     = 1'b0;
   logic n_reset = 1'b0;

   sseg_scan_mux_if bus_if ();

   sseg_scan_mux #(.REFRESH_BITS(RB)) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .bus     (bus_if.slave)
   );

   always #5 clk = ~clk;

   // Segment table g..a, active-low, indexed by hex digit.
   logic [6:0] seg7 [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic [12:0] exp_q [$];      // {frame_tick, an, sseg}
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;

   // Reference model state: cycles since reset release and the captured frame data.
   int          pos      = 0;
   logic [15:0] sh_val   = 16'h0000;
   logic [3:0]  sh_dp    = 4'h0;
   logic [3:0]  sh_blank = 4'h0;

   logic [15:0] cur_val   = 16'h1234;
   logic [3:0]  cur_dp    = 4'h0;
   logic [3:0]  cur_blank = 4'h0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Expected outputs after the edge at which the frame position is p.
   function automatic logic [12:0] model_out(input int p);
      int         d;
      logic [3:0] nib;
      bit         dark;
      logic [3:0] an_e;
      logic [7:0] ss_e;
      d    = p / SLOT;
      nib  = 4'((sh_val >> (4 * d)) & 16'h000F);
      dark = sh_blank[d];
`ifdef SSEG_LEADING_ZERO_BLANK_EN
      if (d > 0 && (sh_val >> (4 * d)) == 16'h0000) dark = 1'b1;
`endif
      if (dark) begin
         an_e = 4'hF;
         ss_e = 8'hFF;
      end else begin
         an_e = ~(4'b0001 << d);
         ss_e = {~sh_dp[d], seg7[nib]};
      end
      return {(p == FRAME - 1) ? 1'b1 : 1'b0, an_e, ss_e};
   endfunction

   // One clock of stimulus: drive on the falling edge, predict the next rising edge.
   task automatic cycle(input logic rst_v);
      logic prev_rst;
      int   p;
      @(negedge clk);
      prev_rst          = n_reset;
      n_reset           = rst_v;
      bus_if.value_in   = cur_val;
      bus_if.dp_in      = cur_dp;
      bus_if.blank_in   = cur_blank;
      if (!rst_v) begin
         pos      = 0;
         sh_val   = 16'h0000;
         sh_dp    = 4'h0;
         sh_blank = 4'h0;
         exp_q.push_back({1'b0, 4'hF, 8'hFF});
         if (prev_rst) begin
            #1;
            chk("async_rst_an", {4'h0, bus_if.an}, 8'h0F);
            chk("async_rst_sseg", bus_if.sseg, 8'hFF);
            chk("async_rst_tick", {7'h00, bus_if.frame_tick}, 8'h00);
         end
      end else begin
         p = pos % FRAME;
         exp_q.push_back(model_out(p));
         if (p == FRAME - 1) begin
            sh_val   = cur_val;
            sh_dp    = cur_dp;
            sh_blank = cur_blank;
         end
         pos++;
      end
      mon_en = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b1);
   endtask

   // Monitor: compare every registered output against the scoreboard.
   initial begin
      logic [12:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow", 8'h01, 8'h00);
            end else begin
               e = exp_q.pop_front();
               chk("an", {4'h0, bus_if.an}, {4'h0, e[11:8]});
               chk("sseg", bus_if.sseg, e[7:0]);
               chk("frame_tick", {7'h00, bus_if.frame_tick}, {7'h00, e[12]});
               chk("an_onehot0", 8'($countones(~bus_if.an) <= 1), 8'h01);
            end
         end
      end
   end

   // Driver: directed scenarios followed by randomized traffic.
   initial begin
      bus_if.value_in = 16'h1234;
      bus_if.dp_in    = 4'h0;
      bus_if.blank_in = 4'h0;
      cur_val = 16'h1234;
      for (int i = 0; i < 3; i++) cycle(1'b0);
      // Frames 1-2 with 1234, switch to ABCD mid frame 2, then frame 3.
      run(20);
      cur_val = 16'hABCD;
      run(FRAME * 2 - 20 + FRAME);
      // Decimal points on digits 0 and 2.
      cur_val = 16'h8888;
      cur_dp  = 4'b0101;
      run(FRAME * 2);
      // Blank the most significant digit.
      cur_dp    = 4'h0;
      cur_val   = 16'h1234;
      cur_blank = 4'b1000;
      run(FRAME * 2);
      cur_blank = 4'h0;
      // Reset for one cycle inside the digit 2 slot.
      while ((pos % FRAME) != 9) cycle(1'b1);
      cycle(1'b0);
      run(FRAME * 2);
      // Leading-zero values.
      cur_val = 16'h0050;
      run(FRAME * 2);
      cur_val = 16'h0000;
      run(FRAME * 2);
      // Randomized traffic with occasional short resets.
      for (int i = 0; i < FRAME * 40; i++) begin
         if ($urandom_range(7) == 0) begin
            cur_val = 16'($urandom) & (($urandom_range(1) == 0) ? 16'hFFFF : 16'h00FF);
            cur_dp  = 4'($urandom);
            cur_blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
         end
         cycle(($urandom_range(199) == 0) ? 1'b0 : 1'b1);
      end
      run(FRAME);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
